// File: rtl/on_off_input_port_pkg.sv
// Shared NoC link parameters, flit format and on/off state encoding.
package noc_params;

  localparam int VC_NUM      = 2;
  localparam int VC_SIZE     = 2;  // one spare bit so out-of-range VC ids are representable
  localparam int BUFFER_SIZE = 8;
  localparam int DATA_W      = 8;
  localparam int OCC_W       = $clog2(BUFFER_SIZE) + 1;

  typedef struct packed {
    logic [VC_SIZE-1:0] vc_id;
    logic [DATA_W-1:0]  data;
  } flit_t;

  typedef enum logic {ON = 1'b0, OFF = 1'b1} on_off_state_t;

endpackage

// File: rtl/on_off_input_port_if.sv
// Link-side bundle of the on/off input port; stats ports exist only with ON_OFF_PORT_STATS_EN.
interface on_off_input_port_if;
  import noc_params::*;

  flit_t                     data_i;
  logic                      valid_flit_i;
  logic [VC_NUM-1:0]         read_i;
  flit_t [VC_NUM-1:0]        flit_o;
  logic [VC_NUM-1:0]         is_empty_o;
  logic [VC_NUM-1:0]         on_off_o;
  logic                      error_o;
`ifdef ON_OFF_PORT_STATS_EN
  logic [VC_NUM-1:0][OCC_W-1:0] peak_occ_o;
  logic [VC_NUM-1:0][15:0]      off_count_o;
`endif

  modport slave (
    input  data_i, valid_flit_i, read_i,
    output flit_o, is_empty_o, on_off_o, error_o
`ifdef ON_OFF_PORT_STATS_EN
    , output peak_occ_o, off_count_o
`endif
  );

  modport master (
    output data_i, valid_flit_i, read_i,
    input  flit_o, is_empty_o, on_off_o, error_o
`ifdef ON_OFF_PORT_STATS_EN
    , input peak_occ_o, off_count_o
`endif
  );

endinterface

// File: rtl/on_off_input_port_vc_onoff_fifo.sv
// One VC buffer: FWFT FIFO, occupancy counter and on/off hysteresis FSM.
// state | meaning:  ON | upstream may send   OFF | upstream must stop
module vc_onoff_fifo
  import noc_params::*;
#(
  parameter int BUFFER_SIZE   = 8,
  parameter int OFF_THRESHOLD = 6,
  parameter int ON_THRESHOLD  = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_wr,
  input  flit_t i_data,
  input  logic  i_rd,
  output flit_t o_head,
  output logic  o_empty,
  output logic  o_on,
  output logic  o_ovf,
  output logic  o_udf
`ifdef ON_OFF_PORT_STATS_EN
  , output logic [$clog2(BUFFER_SIZE):0] o_occ
  , output logic                         o_going_off
`endif
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  flit_t            r_mem [BUFFER_SIZE];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_occ, w_next_occ;
  logic             w_full, w_empty, w_wr_ok, w_rd_ok;
  on_off_state_t    r_state, w_state_nxt;

  assign w_full     = (r_occ == CNT_W'(BUFFER_SIZE));
  assign w_empty    = (r_occ == '0);
  assign w_wr_ok    = i_wr && !w_full;
  assign w_rd_ok    = i_rd && !w_empty;
  assign w_next_occ = r_occ + CNT_W'(w_wr_ok) - CNT_W'(w_rd_ok);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ON:      if (w_next_occ >= CNT_W'(OFF_THRESHOLD)) w_state_nxt = OFF;
      OFF:     if (w_next_occ <= CNT_W'(ON_THRESHOLD))  w_state_nxt = ON;
      default: w_state_nxt = ON;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_state  <= ON;
      for (int i = 0; i < BUFFER_SIZE; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ   <= w_next_occ;
      r_state <= w_state_nxt;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_on    = (r_state == ON);
  assign o_ovf   = i_wr && w_full;
  assign o_udf   = i_rd && w_empty;
`ifdef ON_OFF_PORT_STATS_EN
  assign o_occ       = r_occ;
  assign o_going_off = (r_state == ON) && (w_state_nxt == OFF);
`endif

endmodule

// File: rtl/on_off_input_port.sv
// Router link receiver: steers flits into per-VC on/off FIFOs, sticky error flag.
// Optional per-VC peak occupancy / off-transition counters with ON_OFF_PORT_STATS_EN.
module on_off_input_port
  import noc_params::*;
#(
  parameter int OFF_THRESHOLD = 6,
  parameter int ON_THRESHOLD  = 3
) (
  input logic               clk,
  input logic               rst,
  on_off_input_port_if.slave port_if
);

  logic [VC_NUM-1:0]  w_wr, w_empty, w_on, w_ovf, w_udf;
  flit_t [VC_NUM-1:0] w_head;
  logic               w_bad_vc;
  logic               r_error;
`ifdef ON_OFF_PORT_STATS_EN
  logic [VC_NUM-1:0][OCC_W-1:0] w_occ, r_peak;
  logic [VC_NUM-1:0]            w_going_off;
  logic [VC_NUM-1:0][15:0]      r_off_cnt;
`endif

  assign w_bad_vc = port_if.valid_flit_i && (port_if.data_i.vc_id >= VC_SIZE'(VC_NUM));

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign w_wr[v] = port_if.valid_flit_i && (port_if.data_i.vc_id == VC_SIZE'(v));

    vc_onoff_fifo #(
      .BUFFER_SIZE  (BUFFER_SIZE),
      .OFF_THRESHOLD(OFF_THRESHOLD),
      .ON_THRESHOLD (ON_THRESHOLD)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_wr   (w_wr[v]),
      .i_data (port_if.data_i),
      .i_rd   (port_if.read_i[v]),
      .o_head (w_head[v]),
      .o_empty(w_empty[v]),
      .o_on   (w_on[v]),
      .o_ovf  (w_ovf[v]),
      .o_udf  (w_udf[v])
`ifdef ON_OFF_PORT_STATS_EN
      , .o_occ      (w_occ[v])
      , .o_going_off(w_going_off[v])
`endif
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_error <= 1'b0;
    else     r_error <= r_error | w_bad_vc | (|w_ovf) | (|w_udf);
  end

  assign port_if.flit_o     = w_head;
  assign port_if.is_empty_o = w_empty;
  assign port_if.on_off_o   = w_on;
  assign port_if.error_o    = r_error;

`ifdef ON_OFF_PORT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak    <= '0;
      r_off_cnt <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_occ[v] > r_peak[v]) r_peak[v] <= w_occ[v];
        if (w_going_off[v] && (r_off_cnt[v] != 16'hFFFF)) r_off_cnt[v] <= r_off_cnt[v] + 16'd1;
      end
    end
  end

  assign port_if.peak_occ_o  = r_peak;
  assign port_if.off_count_o = r_off_cnt;
`endif

endmodule

// File: tb/tb_on_off_input_port.sv
// Directed vector bench for on_off_input_port: table-driven fill/drain plus hand sequences.
`timescale 1ns/1ps
module tb_on_off_input_port;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  on_off_input_port_if port_if ();
  on_off_input_port dut (.clk(clk), .rst(rst), .port_if(port_if));

  typedef struct {
    logic       valid;
    logic [1:0] vc;
    logic [7:0] data;
    logic [1:0] rd;
    logic [1:0] exp_on;
    logic [1:0] exp_empty;
    logic       exp_err;
    logic       chk_h0;
    logic [7:0] exp_h0;
    logic       chk_h1;
    logic [7:0] exp_h1;
  } vec_t;

  vec_t vecs [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic valid, logic [1:0] vc, logic [7:0] data, logic [1:0] rd,
                              logic [1:0] on, logic [1:0] empty, logic err,
                              logic c0, logic [7:0] h0, logic c1, logic [7:0] h1);
    vec_t v;
    v.valid = valid; v.vc = vc; v.data = data; v.rd = rd;
    v.exp_on = on; v.exp_empty = empty; v.exp_err = err;
    v.chk_h0 = c0; v.exp_h0 = h0; v.chk_h1 = c1; v.exp_h1 = h1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic valid, logic [1:0] vc, logic [7:0] data, logic [1:0] rd);
    port_if.valid_flit_i = valid;
    port_if.data_i.vc_id = vc;
    port_if.data_i.data  = data;
    port_if.read_i       = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 8'h00, 2'b00);
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, 8'h00, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 2'd0, 8'h00, 2'b00);

    // Fill VC0 1..8, overflow with 9, hysteresis drain, VC1 simultaneous rd/wr, drain both.
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(1, 0, 8'(i), 2'b00, 2'b11, 2'b10, 0, 1, 8'd1, 0, 0));
    for (int i = 6; i <= 8; i++) vecs.push_back(mk(1, 0, 8'(i), 2'b00, 2'b10, 2'b10, 0, 1, 8'd1, 0, 0));
    vecs.push_back(mk(1, 0, 8'd9, 2'b00, 2'b10, 2'b10, 1, 1, 8'd1, 0, 0));
    for (int i = 2; i <= 5; i++) vecs.push_back(mk(0, 0, 0, 2'b01, 2'b10, 2'b10, 1, 1, 8'(i), 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b10, 1, 1, 8'd6, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA1, 2'b00, 2'b11, 2'b00, 1, 1, 8'd6, 1, 8'hA1));
    vecs.push_back(mk(1, 1, 8'hB2, 2'b00, 2'b11, 2'b00, 1, 1, 8'd6, 1, 8'hA1));
    vecs.push_back(mk(1, 1, 8'hC3, 2'b10, 2'b11, 2'b00, 1, 1, 8'd6, 1, 8'hB2));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b11, 2'b00, 1, 1, 8'd6, 1, 8'hC3));
    vecs.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b00, 1, 1, 8'd7, 1, 8'hC3));
    vecs.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b00, 1, 1, 8'd8, 1, 8'hC3));
    vecs.push_back(mk(0, 0, 0, 2'b11, 2'b11, 2'b11, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h55, 2'b01, 2'b11, 2'b10, 1, 1, 8'h55, 0, 0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_on", 32'(port_if.on_off_o), 32'h3);
    chk("rst_empty", 32'(port_if.is_empty_o), 32'h3);
    chk("rst_err", 32'(port_if.error_o), 32'h0);
    chk("rst_flit", 32'(port_if.flit_o), 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].vc, vecs[i].data, vecs[i].rd);
      tick();
      chk($sformatf("v%0d_on", i), 32'(port_if.on_off_o), 32'(vecs[i].exp_on));
      chk($sformatf("v%0d_empty", i), 32'(port_if.is_empty_o), 32'(vecs[i].exp_empty));
      chk($sformatf("v%0d_err", i), 32'(port_if.error_o), 32'(vecs[i].exp_err));
      if (vecs[i].chk_h0) chk($sformatf("v%0d_h0", i), 32'(port_if.flit_o[0].data), 32'(vecs[i].exp_h0));
      if (vecs[i].chk_h1) chk($sformatf("v%0d_h1", i), 32'(port_if.flit_o[1].data), 32'(vecs[i].exp_h1));
    end

    // Wrap-around: pointers cycle 2.5 times through the buffer.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2'd0, 8'(8'h30 + k), 2'b00);
      tick();
      chk($sformatf("wrap%0d_head", k), 32'(port_if.flit_o[0].data), 32'(8'h30 + k));
      drive(1'b0, 2'd0, 8'h00, 2'b01);
      tick();
      chk($sformatf("wrap%0d_empty", k), 32'(port_if.is_empty_o), 32'h3);
      chk($sformatf("wrap%0d_on", k), 32'(port_if.on_off_o), 32'h3);
    end
    chk("wrap_err", 32'(port_if.error_o), 32'h0);

    // Underflow: read on empty VC0 with a same-cycle write.
    drive(1'b1, 2'd0, 8'h77, 2'b01);
    tick();
    chk("udf_err", 32'(port_if.error_o), 32'h1);
    chk("udf_stored", 32'(port_if.flit_o[0].data), 32'h77);
    chk("udf_empty", 32'(port_if.is_empty_o), 32'h2);

    // Out-of-range VC id is dropped.
    do_reset();
    chk("rst2_err", 32'(port_if.error_o), 32'h0);
    drive(1'b1, 2'd2, 8'h99, 2'b00);
    tick();
    chk("badvc_err", 32'(port_if.error_o), 32'h1);
    chk("badvc_empty", 32'(port_if.is_empty_o), 32'h3);

    // Async reset mid-traffic: outputs clear without a clock edge.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 2'(k % 2), 8'(k + 1), 2'b00);
      tick();
    end
    drive(1'b1, 2'd0, 8'hEE, 2'b11);
    tick();
    chk("pre_rst_err", 32'(port_if.error_o), 32'h0);
    chk("pre_rst_empty", 32'(port_if.is_empty_o), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_on", 32'(port_if.on_off_o), 32'h3);
    chk("async_rst_empty", 32'(port_if.is_empty_o), 32'h3);
    chk("async_rst_err", 32'(port_if.error_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/on_off_input_port.md
Name: on_off_input_port

Overview:
- Receiving end of the router-to-router link.
- Accepts flits from the upstream router's crossbar output (flit bus plus valid bit) and steers each flit into a per-VC FIFO chosen by the flit's VC id.
- Generates the per-VC on/off flow-control bits that the upstream switch allocator samples before granting.
- On/off uses occupancy thresholds with hysteresis, so in-flight flits never overflow a buffer.

Parameters:
- VC_NUM, 2, number of virtual channels on the link.
- BUFFER_SIZE, 8, flit slots per VC FIFO.
- OFF_THRESHOLD, 6, occupancy at or above which a VC is switched off. Must be ≤ BUFFER_SIZE-2 to cover the round trip.
- ON_THRESHOLD, 3, occupancy at or below which an off VC is switched back on. Must be < OFF_THRESHOLD.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- data_i  input  flit_t  incoming flit; carries vc_id field [VC_SIZE-1:0]
- valid_flit_i  input  1  data_i valid this cycle
- read_i  input  [VC_NUM-1:0]  pop head of VC FIFO (from local switch allocator grant)
- flit_o  output  [VC_NUM-1:0] flit_t  head flit per VC (first-word fall-through)
- is_empty_o  output  [VC_NUM-1:0]  VC FIFO empty
- on_off_o  output  [VC_NUM-1:0]  1 = upstream may send on VC, 0 = stop
- error_o  output  1  sticky: overflow or underflow seen

Behaviour:
- Reset (async, rst=1):
  - all FIFOs empty, pointers and occupancy = 0
  - is_empty_o = all 1s, on_off_o = all 1s, error_o = 0
  - flit_o undefined-but-stable (drive '0)
  - Reset mid-traffic discards all buffered flits immediately.
- Write:
  - When valid_flit_i=1, data_i is written into FIFO[data_i.vc_id] at the clock edge.
  - At most one write per cycle (single link).
  - vc_id ≥ VC_NUM: flit dropped, error_o set.
- Read:
  - read_i[v]=1 pops FIFO[v] at the clock edge.
  - Multiple VCs may be popped in the same cycle; each VC is independent.
  - flit_o[v] shows the new head one cycle after a pop, or after a write to an empty FIFO.
  - No same-cycle bypass from data_i to flit_o.
- Simultaneous write and read on the same VC:
  - Non-empty: both performed, occupancy unchanged.
  - Empty: write performed, read ignored, error_o set (underflow).
- Full: a write to a full VC is dropped and sets error_o; the stored contents are unchanged.
- Wrap-around:
  - Read/write pointers are $clog2(BUFFER_SIZE) bits and wrap modulo BUFFER_SIZE. BUFFER_SIZE must be a power of 2.
  - Occupancy counter is $clog2(BUFFER_SIZE)+1 bits, range 0..BUFFER_SIZE.
- On/off per VC is a 2-state FSM (ON, OFF), evaluated on next occupancy (occ + wr - rd):
  - ON → OFF when next_occ ≥ OFF_THRESHOLD.
  - OFF → ON when next_occ ≤ ON_THRESHOLD.
  - Otherwise the state is held.
  - on_off_o is the registered state, so it changes in the cycle after the triggering edge.
- is_empty_o is combinational from occupancy == 0.
- error_o clears only on rst.

Optional Feature:
- Macro: ON_OFF_PORT_STATS_EN
- Defined:
  - Adds output peak_occ_o [VC_NUM-1:0][$clog2(BUFFER_SIZE):0], holding the per-VC maximum occupancy since reset.
  - Adds output off_count_o [VC_NUM-1:0][15:0], counting ON→OFF transitions; saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: neither port nor register exists; behaviour is otherwise identical.

Decomposition:
- Package noc_params holds:
  - flit_t (including vc_id)
  - VC_NUM, VC_SIZE, BUFFER_SIZE defaults
  - on_off_state_t enum {ON, OFF}
- Sub-module vc_onoff_fifo is instanced VC_NUM times. Each instance contains:
  - FIFO storage, pointers and occupancy counter
  - the on/off FSM
  - local overflow/underflow flags
- Top level handles:
  - vc_id decode to per-VC write enable
  - OR-reduction into the sticky error_o
  - optional stats

Test Plan:
- Reset: assert rst asynchronously mid-cycle → on_off_o=2'b11, is_empty_o=2'b11, error_o=0 without waiting for a clk edge.
- Fill VC0 with 6 back-to-back flits (payloads 1..6), no reads → on_off_o[0]=0 in the cycle after the 6th write; on_off_o[1] stays 1.
- Continue with 2 more flits on VC0, then a 9th → occupancy 8, 9th dropped, error_o=1, flit_o[0] still 1.
- Hysteresis: from occupancy 6 (OFF), pop 2 → on_off_o[0] still 0 at occ 4; 1 more pop (occ 3) → on_off_o[0]=1 next cycle.
- Simultaneous write VC1 and read VC1 at occupancy 2 → occupancy stays 2, FIFO order preserved (FIFO order: A, B, C; after the pop flit_o[1] = B). Then read on empty VC0 with a write to VC0 in the same cycle → flit stored, error_o=1.
- Wrap-around: 20 write/read pairs on VC0 with incrementing payloads → every popped flit equals the written sequence; on_off_o[0] stays 1 throughout.
